// File: rtl/ua_rx_param.sv
// Parameterised oversampling UART receiver with a valid/ready output and sticky overrun.
// Optional build macro UA_RX_MAJORITY_EN: 2-of-3 majority vote over the last three enable ticks.
module ua_rx_param #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 ser_in,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_vld,
    input  logic                 dout_rdy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t state_q, state_d;

    logic                 sync1_q, sync2_q;
    logic                 prev_q, prev_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_acc_q, par_acc_d;
    logic                 perr_acc_q, perr_acc_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 dout_vld_q, dout_vld_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;

    logic bit_c;
    logic start_edge_c;
    logic start_pt_c;
    logic sample_c;
    logic complete_c;

`ifdef UA_RX_MAJORITY_EN
    logic prev2_q, prev2_d;
    assign bit_c = (sync2_q & prev_q) | (sync2_q & prev2_q) | (prev_q & prev2_q);
`else
    assign bit_c = sync2_q;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_edge_c) state_d = S_START;
            S_START:  if (start_pt_c) state_d = bit_c ? S_IDLE : S_DATA;
            S_DATA: begin
                if (sample_c && bit_cnt_q == DATA_LAST)
                    state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (sample_c) state_d = S_STOP;
            S_STOP:   if (complete_c) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Decoded control strobes for the datapath
    always_comb begin
        start_edge_c = 1'b0;
        start_pt_c   = 1'b0;
        sample_c     = 1'b0;
        complete_c   = 1'b0;
        if (enable) begin
            start_edge_c = (state_q == S_IDLE) && !sync2_q && prev_q;
            start_pt_c   = (state_q == S_START) && (cnt_q == CNT_HALF);
            sample_c     = (state_q == S_DATA || state_q == S_PARITY || state_q == S_STOP)
                           && (cnt_q == CNT_LAST);
            complete_c   = sample_c && (state_q == S_STOP) && (bit_cnt_q == STOP_LAST);
        end
    end

    // Sampler, shifter, error accumulation and output handshake
    always_comb begin
        prev_d       = prev_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_acc_d    = par_acc_q;
        perr_acc_d   = perr_acc_q;
        ferr_acc_d   = ferr_acc_q;
        dout_d       = dout_q;
        dout_vld_d   = dout_vld_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        busy_d       = (state_d != S_IDLE);
`ifdef UA_RX_MAJORITY_EN
        prev2_d      = prev2_q;
`endif

        if (enable) begin
            prev_d = sync2_q;
`ifdef UA_RX_MAJORITY_EN
            prev2_d = prev_q;
`endif
            case (state_q)
                S_IDLE:  cnt_d = '0;
                S_START: cnt_d = start_pt_c ? '0 : cnt_q + CNT_W'(1);
                default: cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            endcase

            if (state_d != state_q) bit_cnt_d = '0;
            else if (sample_c)      bit_cnt_d = bit_cnt_q + BIT_W'(1);

            if (state_q == S_START) begin
                par_acc_d  = 1'b0;
                perr_acc_d = 1'b0;
                ferr_acc_d = 1'b0;
            end

            if (sample_c) begin
                case (state_q)
                    S_DATA: begin
                        shreg_d   = {bit_c, shreg_q[DATA_BITS-1:1]};
                        par_acc_d = par_acc_q ^ bit_c;
                    end
                    S_PARITY: perr_acc_d = (PARITY_MODE == 2) ? ~(par_acc_q ^ bit_c)
                                                              :  (par_acc_q ^ bit_c);
                    S_STOP:   ferr_acc_d = ferr_acc_q | ~bit_c;
                    default:  ;
                endcase
            end
        end

        // A completing word wins over a plain handshake; it is dropped only when the slot is held
        if (complete_c) begin
            if (!dout_vld_q || dout_rdy) begin
                dout_d       = shreg_q;
                parity_err_d = perr_acc_q;
                frame_err_d  = ferr_acc_q | ~bit_c;
                dout_vld_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (dout_vld_q && dout_rdy) begin
            dout_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_acc_q    <= 1'b0;
            perr_acc_q   <= 1'b0;
            ferr_acc_q   <= 1'b0;
            dout_q       <= '0;
            dout_vld_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UA_RX_MAJORITY_EN
            prev2_q      <= 1'b1;
`endif
        end else begin
            sync1_q      <= ser_in;
            sync2_q      <= sync1_q;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_acc_q    <= par_acc_d;
            perr_acc_q   <= perr_acc_d;
            ferr_acc_q   <= ferr_acc_d;
            dout_q       <= dout_d;
            dout_vld_q   <= dout_vld_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
`ifdef UA_RX_MAJORITY_EN
            prev2_q      <= prev2_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_vld   = dout_vld_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ua_rx_param.sv
// Directed bench for ua_rx_param: default build plus an even-parity instance.
module tb_ua_rx_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       ser_in;
    logic       dout_rdy;
    logic [7:0] dout0, dout1;
    logic       vld0, vld1, perr0, perr1, ferr0, ferr1, ovr0, ovr1, busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] q0[$];
    logic [9:0] q1[$];

    always #5 clk = ~clk;

    ua_rx_param u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .ser_in(ser_in),
        .dout(dout0), .dout_vld(vld0), .dout_rdy(dout_rdy),
        .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0), .busy(busy0)
    );

    ua_rx_param #(.PARITY_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .ser_in(ser_in),
        .dout(dout1), .dout_vld(vld1), .dout_rdy(1'b1),
        .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1), .busy(busy1)
    );

    // Record every accepted word away from the active edge
    always @(negedge clk) begin
        if (vld0 && dout_rdy) q0.push_back({perr0, ferr0, dout0});
        if (vld1)             q1.push_back({perr1, ferr1, dout1});
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One enable tick is two clocks: enable high for one, low for one
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            enable = 1'b1;
            @(posedge clk); #1;
            enable = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_bit(input logic v, input int glitch_off);
        for (int i = 0; i < 16; i++) begin
            ser_in = (i == glitch_off) ? ~v : v;
            tick_n(1);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input bit par_en,
                              input logic par_v, input int glitch_bit, input int glitch_off);
        logic [7:0] dd;
        dd = d;
        send_bit(1'b0, -1);
        for (int j = 0; j < 8; j++) send_bit(dd[j], (j == glitch_bit) ? glitch_off : -1);
        if (par_en) send_bit(par_v, -1);
        send_bit(stop_v, -1);
        ser_in = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_v;
        logic [7:0] exp_dout;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];
    logic [9:0] w;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h5A, 1'b1, 8'h5A, 1'b0};
        vecs[1] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'h81, 1'b1, 8'h81, 1'b0};
        vecs[4] = '{8'h3C, 1'b0, 8'h3C, 1'b1};

        rst = 1'b1; enable = 1'b0; ser_in = 1'b1; dout_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", int'(dout0), 0);
        check("rst_vld", int'(vld0), 0);
        check("rst_perr", int'(perr0), 0);
        check("rst_ferr", int'(ferr0), 0);
        check("rst_ovr", int'(ovr0), 0);
        check("rst_busy", int'(busy0), 0);
        rst = 1'b0;
        tick_n(4);

        // Table of single frames with dout_rdy held high
        for (int k = 0; k < 5; k++) begin
            q0.delete();
            send_frame(vecs[k].data, vecs[k].stop_v, 1'b0, 1'b0, -1, -1);
            tick_n(3);
            check($sformatf("vec%0d_words", k), q0.size(), 1);
            if (q0.size() > 0) begin
                w = q0.pop_front();
                check($sformatf("vec%0d_dout", k), int'(w[7:0]), int'(vecs[k].exp_dout));
                check($sformatf("vec%0d_ferr", k), int'(w[8]), int'(vecs[k].exp_ferr));
                check($sformatf("vec%0d_perr", k), int'(w[9]), 0);
            end
            check($sformatf("vec%0d_busy", k), int'(busy0), 0);
            check($sformatf("vec%0d_vld", k), int'(vld0), 0);
        end

        // False start: three low ticks then high
        q0.delete();
        ser_in = 1'b0;
        tick_n(3);
        check("fs_busy_hi", int'(busy0), 1);
        ser_in = 1'b1;
        tick_n(9);
        check("fs_busy_lo", int'(busy0), 0);
        tick_n(20);
        check("fs_words", q0.size(), 0);

        // Back-to-back frames with no idle gap
        q0.delete();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1, -1);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, -1, -1);
        tick_n(3);
        check("b2b_words", q0.size(), 2);
        if (q0.size() == 2) begin
            w = q0.pop_front();
            check("b2b_first", int'(w), int'({2'b00, 8'hA5}));
            w = q0.pop_front();
            check("b2b_second", int'(w), int'({2'b00, 8'h3C}));
        end

        // One-tick glitch inside data bit 3: at the sample tick only when voting is built in
        q0.delete();
`ifdef UA_RX_MAJORITY_EN
        send_frame(8'hC9, 1'b1, 1'b0, 1'b0, 3, 8);
`else
        send_frame(8'hC9, 1'b1, 1'b0, 1'b0, 3, 3);
`endif
        tick_n(3);
        check("glitch_words", q0.size(), 1);
        if (q0.size() > 0) begin
            w = q0.pop_front();
            check("glitch_dout", int'(w), int'({2'b00, 8'hC9}));
        end

        // Overrun: second word completes while the first is still held
        dout_rdy = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1, -1);
        tick_n(2);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, -1, -1);
        tick_n(3);
        check("ovr_vld", int'(vld0), 1);
        check("ovr_dout", int'(dout0), 8'h11);
        check("ovr_flag", int'(ovr0), 1);
        dout_rdy = 1'b1;
        @(posedge clk); #1;
        check("ovr_vld_fall", int'(vld0), 0);
        check("ovr_sticky", int'(ovr0), 1);
        check("ovr_accept_words", q0.size(), 1);
        q0.delete();

        // Reset in the middle of a frame discards it and clears overrun
        ser_in = 1'b0;
        tick_n(16);
        ser_in = 1'b1;
        tick_n(20);
        do_reset();
        check("mrst_busy", int'(busy0), 0);
        check("mrst_ovr", int'(ovr0), 0);
        ser_in = 1'b0;
        tick_n(8);
        do_reset();
        ser_in = 1'b1;
        tick_n(200);
        check("mrst_words", q0.size(), 0);
        check("mrst_vld", int'(vld0), 0);

        // Even-parity instance: bad parity then good parity
        q1.delete();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, -1, -1);
        tick_n(3);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, -1, -1);
        tick_n(3);
        check("par_words", q1.size(), 2);
        if (q1.size() == 2) begin
            w = q1.pop_front();
            check("par_bad", int'(w), int'({2'b10, 8'h07}));
            w = q1.pop_front();
            check("par_good", int'(w), int'({2'b00, 8'h07}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
